// File: rtl/array_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous array.
// Reads return through a per-requester response register held until consumed.
module array_arbiter #(
  parameter int AN = 8,
  parameter int DN = 8
) (
  input  logic          i_clk,
  input  logic          i_nrst,

  input  logic          i_req0_valid,
  output logic          o_req0_ready,
  input  logic          i_req0_we,
  input  logic [AN-1:0] i_req0_addr,
  input  logic [DN-1:0] i_req0_wdata,
  output logic          o_resp0_valid,
  input  logic          i_resp0_ready,
  output logic [DN-1:0] o_resp0_data,

  input  logic          i_req1_valid,
  output logic          o_req1_ready,
  input  logic          i_req1_we,
  input  logic [AN-1:0] i_req1_addr,
  input  logic [DN-1:0] i_req1_wdata,
  output logic          o_resp1_valid,
  input  logic          i_resp1_ready,
  output logic [DN-1:0] o_resp1_data,

  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AN-1:0] o_mem_addr,
  output logic [DN-1:0] o_mem_wdata,
  input  logic [DN-1:0] i_mem_rdata
);

  logic          r_lastGrant;
  logic          r_rdPend;
  logic          r_rdId;
  logic          r_resp0Valid;
  logic [DN-1:0] r_resp0Data;
  logic          r_resp1Valid;
  logic [DN-1:0] r_resp1Data;

  logic          w_busy0;
  logic          w_busy1;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_readGrant;
  logic          w_capture0;
  logic          w_capture1;

  // A read is held back while its own read is in flight or its response
  // slot is still occupied and not being drained this cycle.
  always_comb begin
    w_busy0 = r_rdPend && !r_rdId;
    w_busy1 = r_rdPend &&  r_rdId;
    w_elig0 = i_nrst && i_req0_valid &&
              (i_req0_we || (!w_busy0 && (!r_resp0Valid || i_resp0_ready)));
    w_elig1 = i_nrst && i_req1_valid &&
              (i_req1_we || (!w_busy1 && (!r_resp1Valid || i_resp1_ready)));
    w_grant0 = w_elig0 && (!w_elig1 ||  r_lastGrant);
    w_grant1 = w_elig1 && (!w_elig0 || !r_lastGrant);
    w_readGrant = (w_grant0 && !i_req0_we) || (w_grant1 && !i_req1_we);
    w_capture0 = r_rdPend && !r_rdId;
    w_capture1 = r_rdPend &&  r_rdId;
  end

  always_comb begin
    o_req0_ready = w_grant0;
    o_req1_ready = w_grant1;
    o_mem_en     = w_grant0 || w_grant1;
    o_mem_we     = 1'b0;
    o_mem_addr   = i_req0_addr;
    o_mem_wdata  = i_req0_wdata;
    if (w_grant1) begin
      o_mem_we    = i_req1_we;
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
    end else if (w_grant0) begin
      o_mem_we    = i_req0_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_lastGrant  <= 1'b1;
      r_rdPend     <= 1'b0;
      r_rdId       <= 1'b0;
      r_resp0Valid <= 1'b0;
      r_resp0Data  <= '0;
      r_resp1Valid <= 1'b0;
      r_resp1Data  <= '0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_lastGrant <= w_grant1;
      end
      r_rdPend <= w_readGrant;
      if (w_readGrant) begin
        r_rdId <= w_grant1;
      end
      // A fresh capture wins over the consume that would otherwise clear valid.
      if (w_capture0) begin
        r_resp0Valid <= 1'b1;
        r_resp0Data  <= i_mem_rdata;
      end else if (r_resp0Valid && i_resp0_ready) begin
        r_resp0Valid <= 1'b0;
      end
      if (w_capture1) begin
        r_resp1Valid <= 1'b1;
        r_resp1Data  <= i_mem_rdata;
      end else if (r_resp1Valid && i_resp1_ready) begin
        r_resp1Valid <= 1'b0;
      end
    end
  end

  assign o_resp0_valid = r_resp0Valid;
  assign o_resp0_data  = r_resp0Data;
  assign o_resp1_valid = r_resp1Valid;
  assign o_resp1_data  = r_resp1Data;

endmodule

// File: tb/tb_array_arbiter.sv
// Bench for array_arbiter: directed scenarios with literal expectations plus a
// cycle-level reference model of arbitration, memory contents and responses.
module tb_array_arbiter;

  logic       clk = 1'b0;
  logic       nrst;
  logic       req0Valid, req0We, req1Valid, req1We;
  logic [7:0] req0Addr, req0Wdata, req1Addr, req1Wdata;
  logic       resp0Ready, resp1Ready;
  logic       req0Ready, req1Ready, resp0Valid, resp1Valid;
  logic [7:0] resp0Data, resp1Data;
  logic       memEn, memWe;
  logic [7:0] memAddr, memWdata, memRdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_arbiter #(.AN(8), .DN(8)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req0_valid(req0Valid), .o_req0_ready(req0Ready), .i_req0_we(req0We),
    .i_req0_addr(req0Addr), .i_req0_wdata(req0Wdata),
    .o_resp0_valid(resp0Valid), .i_resp0_ready(resp0Ready), .o_resp0_data(resp0Data),
    .i_req1_valid(req1Valid), .o_req1_ready(req1Ready), .i_req1_we(req1We),
    .i_req1_addr(req1Addr), .i_req1_wdata(req1Wdata),
    .o_resp1_valid(resp1Valid), .i_resp1_ready(resp1Ready), .o_resp1_data(resp1Data),
    .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata), .i_mem_rdata(memRdata)
  );

  // Synchronous single-port array, preloaded with (i*7)&0x7f.
  logic [7:0] arrayMem [256];
  initial begin
    for (int i = 0; i < 256; i++) arrayMem[i] = 8'((i * 7) & 127);
    memRdata = 8'h00;
    forever begin
      @(posedge clk);
      if (memEn) begin
        if (memWe) arrayMem[memAddr] <= memWdata;
        else       memRdata <= arrayMem[memAddr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic v1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1,
                               input logic rr0, input logic rr1);
    req0Valid = v0; req0We = w0; req0Addr = a0; req0Wdata = d0;
    req1Valid = v1; req1We = w1; req1Addr = a1; req1Wdata = d1;
    resp0Ready = rr0; resp1Ready = rr1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state is what must hold after the coming rising edge.
  logic [7:0] refMem [256];
  bit         mKnown;
  int         mLast;
  bit         mFlight [2];
  logic [7:0] mFlightD [2];
  bit         mRespV [2];
  logic [7:0] mRespD [2];
  int         gap [2];

  initial begin
    logic       v [2], we [2], rr [2], rdy [2], elig [2], rv [2];
    logic [7:0] ad [2], wd [2], rd [2];
    int         g;
    mKnown = 0;
    gap = '{0, 0};
    for (int i = 0; i < 256; i++) refMem[i] = 8'((i * 7) & 127);
    forever begin
      @(negedge clk);
      v[0] = req0Valid;  we[0] = req0We;  ad[0] = req0Addr;  wd[0] = req0Wdata;
      v[1] = req1Valid;  we[1] = req1We;  ad[1] = req1Addr;  wd[1] = req1Wdata;
      rr[0] = resp0Ready; rr[1] = resp1Ready;
      rdy[0] = req0Ready; rdy[1] = req1Ready;
      rv[0] = resp0Valid; rv[1] = resp1Valid;
      rd[0] = resp0Data;  rd[1] = resp1Data;
      if (mKnown) begin
        for (int k = 0; k < 2; k++)
          elig[k] = nrst && v[k] && (we[k] || (!mFlight[k] && (!mRespV[k] || rr[k])));
        g = -1;
        if (elig[0] && elig[1]) g = (mLast == 0) ? 1 : 0;
        else if (elig[0])       g = 0;
        else if (elig[1])       g = 1;
        checkOutput("model_req0_ready", 32'(rdy[0]), 32'(g == 0));
        checkOutput("model_req1_ready", 32'(rdy[1]), 32'(g == 1));
        checkOutput("model_mem_en", 32'(memEn), 32'(g >= 0));
        checkOutput("model_mem_we", 32'(memWe), (g >= 0) ? 32'(we[g]) : 32'd0);
        if (g >= 0) begin
          checkOutput("model_mem_addr", 32'(memAddr), 32'(ad[g]));
          if (we[g]) checkOutput("model_mem_wdata", 32'(memWdata), 32'(wd[g]));
        end
        for (int k = 0; k < 2; k++) begin
          checkOutput((k == 0) ? "model_resp0_valid" : "model_resp1_valid",
                      32'(rv[k]), 32'(mRespV[k]));
          checkOutput((k == 0) ? "model_resp0_data" : "model_resp1_data",
                      32'(rd[k]), 32'(mRespD[k]));
          if (elig[k]) begin
            gap[k] = rdy[k] ? 0 : gap[k] + 1;
            checkOutput((k == 0) ? "starve_gap0" : "starve_gap1", 32'(gap[k] < 2), 32'd1);
          end else begin
            gap[k] = 0;
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (mFlight[k]) begin
            mRespV[k] = 1;
            mRespD[k] = mFlightD[k];
          end else if (mRespV[k] && rr[k]) begin
            mRespV[k] = 0;
          end
          mFlight[k] = 0;
        end
        if (g >= 0) begin
          mLast = g;
          if (we[g]) refMem[ad[g]] = wd[g];
          else begin
            mFlight[g]  = 1;
            mFlightD[g] = refMem[ad[g]];
          end
        end
      end
      if (!nrst) begin
        mKnown = 1;
        mLast = 1;
        mFlight = '{0, 0};
        mRespV = '{0, 0};
        mRespD = '{8'h00, 8'h00};
        gap = '{0, 0};
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       acc0, acc1;
    logic [7:0] a0, a1;
    logic       sv [2], swe [2], sacc [2];
    logic [7:0] sa [2], sd [2];

    nrst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset holds grants off even with valid requests present.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h99, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rst_req0_ready", 32'(req0Ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1Ready), 32'd0);
    checkOutput("rst_mem_en", 32'(memEn), 32'd0);
    checkOutput("rst_mem_we", 32'(memWe), 32'd0);
    checkOutput("rst_resp0_valid", 32'(resp0Valid), 32'd0);
    checkOutput("rst_resp1_valid", 32'(resp1Valid), 32'd0);
    checkOutput("rst_resp0_data", 32'(resp0Data), 32'd0);
    checkOutput("rst_resp1_data", 32'(resp1Data), 32'd0);

    // Tie after reset: requester 0 first, then requester 1.
    nextCycle();
    nrst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h03, 8'h15, 1'b1, 1'b1, 8'h04, 8'h2A, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("tie_req0_ready", 32'(req0Ready), 32'd1);
    checkOutput("tie_req1_ready", 32'(req1Ready), 32'd0);
    checkOutput("tie_mem_we", 32'(memWe), 32'd1);
    checkOutput("tie_mem_addr", 32'(memAddr), 32'h03);
    checkOutput("tie_mem_wdata", 32'(memWdata), 32'h15);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h04, 8'h2A, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("tie2_req1_ready", 32'(req1Ready), 32'd1);
    checkOutput("tie2_mem_addr", 32'(memAddr), 32'h04);
    checkOutput("tie2_mem_wdata", 32'(memWdata), 32'h2A);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rd_req0_ready", 32'(req0Ready), 32'd1);
    checkOutput("rd_req1_ready", 32'(req1Ready), 32'd0);
    checkOutput("rd_mem_we", 32'(memWe), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rd_req1_ready", 32'(req1Ready), 32'd1);
    checkOutput("rd_mem_addr", 32'(memAddr), 32'h04);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rd_resp0_valid", 32'(resp0Valid), 32'd1);
    checkOutput("rd_resp0_data", 32'(resp0Data), 32'h15);
    checkOutput("rd_resp1_early", 32'(resp1Valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_resp1_valid", 32'(resp1Valid), 32'd1);
    checkOutput("rd_resp1_data", 32'(resp1Data), 32'h2A);
    checkOutput("rd_resp0_cleared", 32'(resp0Valid), 32'd0);

    // Alternating reads: one array read per cycle, grants 0,1,0,1...
    a0 = 8'h20; a1 = 8'h40; acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (acc0) a0 = a0 + 8'd1;
      if (acc1) a1 = a1 + 8'd1;
      applyStimulus(1'b1, 1'b0, a0, 8'h00, 1'b1, 1'b0, a1, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("alt_mem_en", 32'(memEn), 32'd1);
      checkOutput("alt_req0_ready", 32'(req0Ready), 32'(i % 2 == 0));
      checkOutput("alt_req1_ready", 32'(req1Ready), 32'(i % 2 == 1));
      if (i >= 2 && i % 2 == 0) begin
        checkOutput("alt_resp0_valid", 32'(resp0Valid), 32'd1);
        checkOutput("alt_resp0_data", 32'(resp0Data), 32'(((32 + (i - 2) / 2) * 7) & 127));
      end
      if (i >= 3 && i % 2 == 1) begin
        checkOutput("alt_resp1_valid", 32'(resp1Valid), 32'd1);
        checkOutput("alt_resp1_data", 32'(resp1Data), 32'(((64 + (i - 3) / 2) * 7) & 127));
      end
      acc0 = req0Ready;
      acc1 = req1Ready;
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    end

    // Backpressure on response 0 blocks the next read until consumed.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_grant_ready0", 32'(req0Ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_inflight_ready0", 32'(req0Ready), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_resp0_valid", 32'(resp0Valid), 32'd1);
    checkOutput("bp_resp0_data", 32'(resp0Data), 32'h23);
    checkOutput("bp_hold_ready0", 32'(req0Ready), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_hold2_ready0", 32'(req0Ready), 32'd0);
    checkOutput("bp_stable_data", 32'(resp0Data), 32'h23);
    nextCycle();
    resp0Ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready0", 32'(req0Ready), 32'd1);
    checkOutput("bp_release_addr", 32'(memAddr), 32'h06);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_gap_valid", 32'(resp0Valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_next_valid", 32'(resp0Valid), 32'd1);
    checkOutput("bp_next_data", 32'(resp0Data), 32'h2A);
    nextCycle();
    resp0Ready = 1'b1;

    // Read-after-write across requesters.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("raw_req1_ready", 32'(req1Ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("raw_req0_ready", 32'(req0Ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("raw_resp0_valid", 32'(resp0Valid), 32'd1);
    checkOutput("raw_resp0_data", 32'(resp0Data), 32'h55);

    // Reset in the cycle after a read grant discards the read.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mr_req1_ready", 32'(req1Ready), 32'd1);
    nextCycle();
    nrst = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mr_rst_ready0", 32'(req0Ready), 32'd0);
    checkOutput("mr_rst_mem_en", 32'(memEn), 32'd0);
    nextCycle();
    nrst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h31, 8'h12, 1'b1, 1'b1, 8'h32, 8'h13, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mr_resp1_valid", 32'(resp1Valid), 32'd0);
    checkOutput("mr_resp1_data", 32'(resp1Data), 32'd0);
    checkOutput("mr_resp0_data", 32'(resp0Data), 32'd0);
    checkOutput("mr_tie_req0_ready", 32'(req0Ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h32, 8'h13, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mr_resp1_late", 32'(resp1Valid), 32'd0);
    checkOutput("mr_req1_ready", 32'(req1Ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

    // Random traffic; unaccepted commands are held stable.
    sv = '{1'b0, 1'b0}; swe = '{1'b0, 1'b0}; sacc = '{1'b0, 1'b0};
    sa = '{8'h00, 8'h00}; sd = '{8'h00, 8'h00};
    for (int n = 0; n < 1000; n++) begin
      nextCycle();
      for (int k = 0; k < 2; k++) begin
        if (!(sv[k] && !sacc[k])) begin
          sv[k]  = ($urandom_range(0, 3) != 0);
          swe[k] = 1'($urandom_range(0, 1));
          sa[k]  = 8'($urandom_range(0, 15));
          sd[k]  = 8'($urandom);
        end
      end
      applyStimulus(sv[0], swe[0], sa[0], sd[0], sv[1], swe[1], sa[1], sd[1],
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      @(negedge clk);
      sacc[0] = sv[0] && req0Ready;
      sacc[1] = sv[1] && req1Ready;
    end
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
